// File: rtl/moving_average_filter.sv
// Streaming signed boxcar filter: registered mean of the last N accepted samples.
// Optional macro MOVING_AVERAGE_ROUND_EN selects round-half-up with saturation instead of floor.
module moving_average_filter #(
  parameter int unsigned WL = 32,
  parameter int unsigned N  = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic signed [WL-1:0] data_in,
  output logic signed [WL-1:0] data_out
);

  localparam int unsigned LOG2N = $clog2(N);
  localparam int unsigned SW    = WL + LOG2N;

  // Reject illegal window lengths at elaboration time.
  if ((N < 2) || ((N & (N - 1)) != 0) || (WL < 2)) begin : g_param_check
    $error("moving_average_filter: N must be a power of two >= 2 and WL >= 2");
  end

  logic signed [WL-1:0] hist [N];
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_next;
  logic signed [WL-1:0] avg_c;

  // Running sum updated incrementally: add the newest sample, drop the oldest.
  always_comb begin
    sum_next = sum + SW'(data_in) - SW'(hist[N-1]);
  end

`ifdef MOVING_AVERAGE_ROUND_EN
  localparam int unsigned RW = SW + 1;
  localparam logic signed [WL-1:0] MAX_VAL = {1'b0, {(WL-1){1'b1}}};

  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] shf;
  logic                 ovf;

  // Round half up; only the upper range can overflow since the bias is positive.
  always_comb begin
    rnd = RW'(sum_next) + RW'(N / 2);
    shf = rnd >>> LOG2N;
    ovf = ~shf[RW-1] && (shf[RW-2:WL-1] != '0);
    avg_c = ovf ? MAX_VAL : shf[WL-1:0];
  end
`else
  always_comb begin
    avg_c = WL'(sum_next >>> LOG2N);
  end
`endif

  // History, sum and output advance together on each accepted sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < int'(N); k++) hist[k] <= '0;
      sum      <= '0;
      data_out <= '0;
    end else if (EN) begin
      hist[0] <= data_in;
      for (int k = 1; k < int'(N); k++) hist[k] <= hist[k-1];
      sum      <= sum_next;
      data_out <= avg_c;
    end
  end

endmodule

// File: tb/tb_moving_average_filter.sv
// Scoreboard bench for moving_average_filter: queue-based window model vs registered output.
module tb_moving_average_filter;

  localparam int unsigned WL = 32;
  localparam int unsigned N  = 4;

  logic                 CLK;
  logic                 RST;
  logic                 EN;
  logic signed [WL-1:0] data_in;
  logic signed [WL-1:0] data_out;

  moving_average_filter #(.WL(WL), .N(N)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic signed [WL-1:0] exp_q [$];
  longint               win [$];
  logic signed [WL-1:0] last_exp;
  int                   n_cmp = 0;
  int                   n_bad = 0;
  int                   edge_no = 0;

  // Mean of the window from plain arithmetic on the sample list.
  function automatic logic signed [WL-1:0] avg_ref();
    longint s;
    longint q;
    longint mx;
    s  = 0;
    mx = (longint'(1) <<< (WL - 1)) - 1;
    foreach (win[i]) s += win[i];
`ifdef MOVING_AVERAGE_ROUND_EN
    s += longint'(N / 2);
`endif
    q = s / longint'(N);
    if ((s % longint'(N)) != 0 && s < 0) q -= 1;
    if (q > mx) q = mx;
    return WL'(q);
  endfunction

  task automatic model_step(input logic r, input logic e, input logic signed [WL-1:0] d);
    if (r) begin
      win = {};
      for (int i = 0; i < int'(N); i++) win.push_back(0);
      last_exp = '0;
    end else if (e) begin
      win.push_front(longint'(d));
      void'(win.pop_back());
      last_exp = avg_ref();
    end
    exp_q.push_back(last_exp);
  endtask

  task automatic step(input logic r, input logic e, input logic signed [WL-1:0] d);
    @(negedge CLK);
    RST = r; EN = e; data_in = d;
    @(posedge CLK);
    model_step(r, e, d);
  endtask

  // Monitor: after every edge the registered output is compared with the queued expectation.
  always @(posedge CLK) begin
    #1;
    edge_no++;
    if (exp_q.size() > 0) begin
      logic signed [WL-1:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (data_out !== e) begin
        n_bad++;
        $display("FAIL data_out edge %0d: got %0d (0x%08h), expected %0d (0x%08h)",
                 edge_no, data_out, data_out, e, e);
      end
    end
  end

  localparam logic signed [WL-1:0] MAXV = 32'sh7FFFFFFF;
  localparam logic signed [WL-1:0] MINV = 32'sh80000000;

  initial begin
    logic signed [WL-1:0] d;
    int drain;
    RST = 1'b1; EN = 1'b0; data_in = '0;
    for (int i = 0; i < int'(N); i++) win.push_back(0);
    last_exp = '0;

    // Reset with EN low, then a zero sample.
    step(1'b1, 1'b0, 32'sd0);
    step(1'b1, 1'b0, 32'sd0);
    step(1'b0, 1'b1, 32'sd0);

    // Ramp, hold, resume.
    for (int v = 2; v <= 9; v++) step(1'b0, 1'b1, WL'(v));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'sd0);
    step(1'b0, 1'b1, 32'sd9);

    // Negative values exercise floor.
    step(1'b1, 1'b0, 32'sd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, -32'sd5);

    // Extremes with no wrap.
    step(1'b1, 1'b0, 32'sd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, MAXV);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, MINV);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, MAXV);

    // Reset mid-ramp with EN high: reset wins, then history starts from zero.
    step(1'b1, 1'b0, 32'sd0);
    for (int v = 2; v <= 4; v++) step(1'b0, 1'b1, WL'(v));
    step(1'b1, 1'b1, 32'sd5);
    step(1'b0, 1'b1, 32'sd8);

    // Randomized traffic: mixed magnitudes, random enable, occasional reset.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       d = WL'($urandom);
        1:       d = WL'(int'($urandom_range(0, 40)) - 20);
        2:       d = ($urandom_range(0, 1) != 0) ? MAXV : MINV;
        default: d = WL'(int'($urandom_range(0, 2000)) - 1000);
      endcase
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), d);
    end

    // Drain with a bounded wait.
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge CLK);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
